// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared constants and request type for the writeback unit
package writeback_unit_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - writeback bus; WRITEBACK_BYPASS_EN adds forwarding signals
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic                 alu_valid;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]      alu_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [REG_IDX_W-1:0] ld_rd;
  logic [XLEN-1:0]      ld_data;
  logic                 ld_issue;
  logic [REG_IDX_W-1:0] ld_issue_rd;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [REG_IDX_W-1:0] rd;
  logic [XLEN-1:0]      writeData;
  logic                 regWrite;
`ifdef WRITEBACK_BYPASS_EN
  logic                 rs1_fwd;
  logic                 rs2_fwd;
  logic [XLEN-1:0]      fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           ld_issue, ld_issue_rd, rs1, rs2,
    input  ld_ready, rs1_busy, rs2_busy, rd, writeData, regWrite,
           rs1_fwd, rs2_fwd, fwd_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           ld_issue, ld_issue_rd, rs1, rs2,
    output ld_ready, rs1_busy, rs2_busy, rd, writeData, regWrite,
           rs1_fwd, rs2_fwd, fwd_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           ld_issue, ld_issue_rd, rs1, rs2,
    input  ld_ready, rs1_busy, rs2_busy, rd, writeData, regWrite
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           ld_issue, ld_issue_rd, rs1, rs2,
    output ld_ready, rs1_busy, rs2_busy, rd, writeData, regWrite
  );
`endif

endinterface

// File: rtl/writeback_unit_load_scoreboard.sv
// rtl/writeback_unit_load_scoreboard.sv - outstanding-load tracking and RAW busy lookup
// WRITEBACK_BYPASS_EN drops the staged write from busy and reports it as a forward hit.
module load_scoreboard
  import writeback_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 done_valid,
  input  logic [REG_IDX_W-1:0] done_rd,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic                 stage_valid,
  input  logic [REG_IDX_W-1:0] stage_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
`ifdef WRITEBACK_BYPASS_EN
  output logic                 rs1_fwd,
  output logic                 rs2_fwd,
`endif
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            rs1_hit;
  logic            rs2_hit;

  // Clear first so a same-cycle reissue of the completing index stays pending.
  always_comb begin
    pending_nxt = pending;
    if (done_valid) pending_nxt[done_rd] = 1'b0;
    if (issue_valid && issue_rd != '0) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign rs1_hit = stage_valid && (stage_rd == rs1);
  assign rs2_hit = stage_valid && (stage_rd == rs2);

`ifdef WRITEBACK_BYPASS_EN
  assign rs1_fwd  = rs1_hit;
  assign rs2_fwd  = rs2_hit;
  assign rs1_busy = (rs1 != '0) && pending[rs1];
  assign rs2_busy = (rs2 != '0) && pending[rs2];
`else
  assign rs1_busy = (rs1 != '0) && (pending[rs1] || rs1_hit);
  assign rs2_busy = (rs2 != '0) && (pending[rs2] || rs2_hit);
`endif

  // Decode must never double-issue a pending register nor let the ALU overtake a load.
  a_issue_pending: assert property (@(posedge clk) disable iff (reset)
    !(issue_valid && issue_rd != '0 && pending[issue_rd] && !(done_valid && done_rd == issue_rd)));
  a_alu_pending: assert property (@(posedge clk) disable iff (reset)
    !(alu_valid && pending[alu_rd]));

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - ALU/load write-port arbiter with staged write and load scoreboard
// WRITEBACK_BYPASS_EN exposes the staged write as a one-cycle forward.
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  writeback_unit_if.slave bus
);

  wb_req_t alu_req;
  wb_req_t ld_req;
  wb_req_t stage_d;
  wb_req_t stage_q;
  logic    ld_fire;

  // ALU results cannot stall, so loads only get the port on ALU-idle cycles.
  assign ld_fire = bus.ld_valid && !bus.alu_valid;
  assign alu_req = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
  assign ld_req  = '{valid: ld_fire, rd: bus.ld_rd, data: bus.ld_data};

  always_comb begin
    stage_d       = stage_q;
    stage_d.valid = 1'b0;
    if (alu_req.valid)     stage_d = alu_req;
    else if (ld_req.valid) stage_d = ld_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign bus.ld_ready  = !bus.alu_valid;
  assign bus.regWrite  = stage_q.valid;
  assign bus.rd        = stage_q.rd;
  assign bus.writeData = stage_q.data;

`ifdef WRITEBACK_BYPASS_EN
  assign bus.fwd_data = stage_q.data;
`endif

  load_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (bus.ld_issue),
    .issue_rd    (bus.ld_issue_rd),
    .done_valid  (ld_fire),
    .done_rd     (bus.ld_rd),
    .alu_valid   (bus.alu_valid),
    .alu_rd      (bus.alu_rd),
    .stage_valid (stage_q.valid),
    .stage_rd    (stage_q.rd),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
`ifdef WRITEBACK_BYPASS_EN
    .rs1_fwd     (bus.rs1_fwd),
    .rs2_fwd     (bus.rs2_fwd),
`endif
    .rs1_busy    (bus.rs1_busy),
    .rs2_busy    (bus.rs2_busy)
  );

endmodule
